// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: one subtractor cell and a borrow flop reused over WIDTH clocks,
// LSB first, producing a registered difference and borrow-out with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             x_bit;
  logic             y_bit;
  logic             d_bit_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  always_comb begin
    x_bit   = a_sr_q[0];
    y_bit   = b_sr_q[0];
    d_bit_d = x_bit ^ y_bit ^ br_q;
    br_d    = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
    res_d   = {d_bit_d, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            res_q   <= '0;
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          res_q  <= res_d;
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          br_q   <= br_d;
          cnt_q  <= cnt_q + 1'b1;
          // Last bit: publish the result; diff/bout otherwise hold across later operations.
          if (cnt_q == LAST_BIT) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial full subtractor and the inverse-operation companion to the team's full adder. It accepts two WIDTH-bit operands and a borrow-in on a start handshake. It processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It then presents the parallel difference and borrow-out with a one-cycle done pulse. It is intended for area-constrained datapaths where one ripple cell is reused over WIDTH cycles.

Parameters:
WIDTH, 8, operand and difference width in bits (legal range 2 to 32).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled at each rising clk edge while not busy
a  input  WIDTH  minuend; captured on the start-accept edge
b  input  WIDTH  subtrahend; captured on the start-accept edge
bin  input  1  borrow-in; captured on the start-accept edge
busy  output  1  high while an operation is shifting
done  output  1  one-cycle pulse; diff and bout are valid in this cycle
diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH
bout  output  1  borrow-out; 1 if and only if a < b + bin (unsigned)

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift registers, borrow flip-flop and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0: latch a, b into shift registers; borrow flip-flop=bin; count=0; next state SHIFT.
- IDLE, start=0: remain in IDLE; outputs hold.
- SHIFT, each edge E1..E_WIDTH:
  - Cell inputs: x = a_sr[0], y = b_sr[0], br = borrow flip-flop.
  - d = x ^ y ^ br.
  - br_next = (~x & y) | (~(x ^ y) & br).
  - d shifts into the MSB of an internal result register (right shift); a_sr and b_sr shift right; count increments.
  - At the edge where count reaches WIDTH-1 (edge E_WIDTH): diff is loaded from the completed result, bout=br_next, next state DONE.
- busy=1 exactly in the SHIFT state, i.e. for the WIDTH cycles following E0.
- DONE: done=1 for exactly one cycle; busy=0.
  - If start=1 at the edge leaving DONE, it is accepted exactly as in IDLE (back-to-back operation); otherwise next state IDLE.
- Latency: start accepted at E0, done high in the cycle after E_WIDTH. One operation every WIDTH+1 cycles.
- diff and bout: registered; change only at the completion edge E_WIDTH or on reset. They hold their value through IDLE and through the next operation's SHIFT cycles until the next completion.
- start while busy=1: ignored. No queuing; the captured operands are unaffected by changes on a, b, bin after E0.
- Reset mid-operation: operation aborted immediately, all outputs zero, no done pulse. The first start after rst_n deasserts is accepted normally.
- Arithmetic identity checked by the bench: {bout, diff} == ({1'b0,a} - {1'b0,b} - bin) mod 2^(WIDTH+1).
- No X propagation: all registers are reset; done never asserts without a preceding accepted start.

Test Plan:
1. WIDTH=8, reset then a=0x05, b=0x03, bin=0, start pulse at E0 -> busy high 8 cycles; done high in the cycle after E8; diff=0x02, bout=0.
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0. Then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
3. Start held high continuously with a=0x10, b=0x01, bin=0 -> done pulses every 9 cycles, diff=0x0F each time; changing a to 0x20 mid-shift does not alter the in-flight result.
4. Reset asserted after E3 of an operation -> busy, done, diff, bout=0 within the same cycle; no done pulse. Next start with a=0x09, b=0x04 -> diff=0x05, bout=0.
5. Exhaustive sweep of all 2^17 (a,b,bin) combinations for WIDTH=8 -> {bout,diff} matches the identity above on every done pulse; done count equals accepted start count.
6. WIDTH=4 instance, a=4'h3, b=4'h7, bin=0 -> done 5 cycles after the start edge; diff=4'hC, bout=1.
